// File: rtl/prescaled_bcd_counter.sv
// Multi-digit BCD up/down counter stepped by a programmable prescaler, with
// synchronous load, wrap-or-saturate limits, tick/tc pulses and 7-segment decode.
module prescaled_bcd_counter #(
    parameter int DIGITS   = 4,
    parameter int PRESC_W  = 26,
    parameter int WRAP     = 1,
    parameter int BLANK_LZ = 0
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  enable,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic [PRESC_W-1:0]    presc_max,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  tick,
    output logic                  tc,
    output logic [8*DIGITS-1:0]   seg
);

    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [4*DIGITS-1:0] count_q, count_d;
    logic                tick_q, tick_d;
    logic                tc_q, tc_d;

    logic [4*DIGITS-1:0] stepVal;
    logic [4*DIGITS-1:0] clampVal;
    logic                atLimit;
    logic                stepEn;
    logic                carry;
    logic                allNine;
    logic                allZero;
    logic [3:0]          stepDig;

    function automatic logic [7:0] font(input logic [3:0] d);
        case (d)
            4'd0:    font = 8'hC0;
            4'd1:    font = 8'hF9;
            4'd2:    font = 8'hA4;
            4'd3:    font = 8'hB0;
            4'd4:    font = 8'h99;
            4'd5:    font = 8'h92;
            4'd6:    font = 8'h82;
            4'd7:    font = 8'hF8;
            4'd8:    font = 8'h80;
            4'd9:    font = 8'h90;
            default: font = 8'hFF;
        endcase
    endfunction

    // Ripple carry/borrow through all digits so the whole count moves in one cycle.
    always_comb begin
        stepVal  = count_q;
        clampVal = load_val;
        carry    = 1'b1;
        allNine  = 1'b1;
        allZero  = 1'b1;
        stepDig  = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            stepDig = count_q[4*i +: 4];
            allNine = allNine && (stepDig == 4'd9);
            allZero = allZero && (stepDig == 4'd0);
            if (carry) begin
                if (up_dn) begin
                    if (stepDig == 4'd9) begin
                        stepVal[4*i +: 4] = 4'd0;
                    end else begin
                        stepVal[4*i +: 4] = stepDig + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (stepDig == 4'd0) begin
                        stepVal[4*i +: 4] = 4'd9;
                    end else begin
                        stepVal[4*i +: 4] = stepDig - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            if (load_val[4*i +: 4] > 4'd9) begin
                clampVal[4*i +: 4] = 4'd9;
            end
        end
        atLimit = up_dn ? allNine : allZero;
        stepEn  = enable && !load && (presc_q >= presc_max);
    end

    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        tick_d  = 1'b0;
        tc_d    = 1'b0;
        if (load) begin
            count_d = clampVal;
            presc_d = '0;
        end else if (stepEn) begin
            presc_d = '0;
            tick_d  = 1'b1;
            tc_d    = atLimit;
            if (!(atLimit && (WRAP == 0))) begin
                count_d = stepVal;
            end
        end else if (enable) begin
            presc_d = presc_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            presc_q <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            tc_q    <= tc_d;
        end
    end

    assign count_bcd = count_q;
    assign tick      = tick_q;
    assign tc        = tc_q;

    logic       zeroAbove;
    logic [3:0] segDig;

    // Walk from the most significant digit down so blanking stops at the first non-zero digit.
    always_comb begin
        seg       = '1;
        zeroAbove = 1'b1;
        segDig    = 4'd0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            segDig    = count_q[4*i +: 4];
            zeroAbove = zeroAbove && (segDig == 4'd0);
            if ((BLANK_LZ != 0) && (i > 0) && zeroAbove) begin
                seg[8*i +: 8] = 8'hFF;
            end else begin
                seg[8*i +: 8] = font(segDig);
            end
        end
    end

endmodule

// File: tb/tb_prescaled_bcd_counter.sv
// Directed bench: one wrapping/unblanked counter and one saturating/blanked counter
// share the same stimulus so both limit policies and both seg modes are observed.
module tb_prescaled_bcd_counter;

    logic        clk;
    logic        clr;
    logic        enable;
    logic        up_dn;
    logic        load;
    logic [15:0] load_val;
    logic [25:0] presc_max;

    logic [15:0] countA, countB;
    logic        tickA, tickB, tcA, tcB;
    logic [31:0] segA, segB;

    int compared;
    int mismatched;

    prescaled_bcd_counter #(.DIGITS(4), .PRESC_W(26), .WRAP(1), .BLANK_LZ(0)) dutWrap (
        .clk(clk), .clr(clr), .enable(enable), .up_dn(up_dn), .load(load),
        .load_val(load_val), .presc_max(presc_max),
        .count_bcd(countA), .tick(tickA), .tc(tcA), .seg(segA)
    );

    prescaled_bcd_counter #(.DIGITS(4), .PRESC_W(26), .WRAP(0), .BLANK_LZ(1)) dutSat (
        .clk(clk), .clr(clr), .enable(enable), .up_dn(up_dn), .load(load),
        .load_val(load_val), .presc_max(presc_max),
        .count_bcd(countB), .tick(tickB), .tc(tcB), .seg(segB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doLoad(input logic [15:0] v);
        load     = 1'b1;
        load_val = v;
        cycle(1);
        load     = 1'b0;
    endtask

    task automatic test_reset;
        clr = 1'b0; enable = 1'b0; up_dn = 1'b1; load = 1'b0;
        load_val = 16'h0; presc_max = 26'd0;
        cycle(2);
        compared++; if (countA !== 16'h0000) begin mismatched++; $display("FAIL reset_countA got %h want 0000", countA); end
        compared++; if ({tickA, tcA, tickB, tcB} !== 4'b0000) begin mismatched++; $display("FAIL reset_pulses got %b want 0000", {tickA, tcA, tickB, tcB}); end
        compared++; if (segA !== 32'hC0C0C0C0) begin mismatched++; $display("FAIL reset_segA got %h want C0C0C0C0", segA); end
        compared++; if (segB !== 32'hFFFFFFC0) begin mismatched++; $display("FAIL reset_segB got %h want FFFFFFC0", segB); end
    endtask

    task automatic test_count_up;
        logic tickErr;
        tickErr = 1'b0;
        clr = 1'b1; presc_max = 26'd3; up_dn = 1'b1; enable = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            cycle(1);
            if (tickA !== ((k % 4) == 0) || tcA !== 1'b0) begin
                tickErr = 1'b1;
                $display("FAIL count_up_tick cycle %0d got tick=%b tc=%b want tick=%b tc=0", k, tickA, tcA, (k % 4) == 0);
            end
        end
        compared++; if (tickErr) mismatched++;
        compared++; if (countA !== 16'h0010) begin mismatched++; $display("FAIL count_up_value got %h want 0010", countA); end
        enable = 1'b0;
        cycle(3);
        compared++; if (countA !== 16'h0010 || tickA !== 1'b0) begin mismatched++; $display("FAIL hold got %h/%b want 0010/0", countA, tickA); end
    endtask

    task automatic test_wrap_up;
        enable = 1'b0;
        doLoad(16'h9998);
        compared++; if (countA !== 16'h9998 || tickA !== 1'b0) begin mismatched++; $display("FAIL load_9998 got %h/%b want 9998/0", countA, tickA); end
        presc_max = 26'd0; up_dn = 1'b1; enable = 1'b1;
        cycle(1);
        compared++; if ({countA, tickA, tcA} !== {16'h9999, 1'b1, 1'b0}) begin mismatched++; $display("FAIL wrap_step1 got %h/%b/%b want 9999/1/0", countA, tickA, tcA); end
        cycle(1);
        compared++; if ({countA, tickA, tcA} !== {16'h0000, 1'b1, 1'b1}) begin mismatched++; $display("FAIL wrap_step2 got %h/%b/%b want 0000/1/1", countA, tickA, tcA); end
        compared++; if ({countB, tickB, tcB} !== {16'h9999, 1'b1, 1'b1}) begin mismatched++; $display("FAIL sat_up got %h/%b/%b want 9999/1/1", countB, tickB, tcB); end
        enable = 1'b0;
        cycle(1);
        compared++; if ({tickA, tcA} !== 2'b00) begin mismatched++; $display("FAIL disable_pulses got %b want 00", {tickA, tcA}); end
    endtask

    task automatic test_saturate_down;
        enable = 1'b0;
        doLoad(16'h0001);
        presc_max = 26'd0; up_dn = 1'b0; enable = 1'b1;
        cycle(1);
        compared++; if ({countB, tickB, tcB} !== {16'h0000, 1'b1, 1'b0}) begin mismatched++; $display("FAIL sat_step1 got %h/%b/%b want 0000/1/0", countB, tickB, tcB); end
        cycle(1);
        compared++; if ({countB, tickB, tcB} !== {16'h0000, 1'b1, 1'b1}) begin mismatched++; $display("FAIL sat_step2 got %h/%b/%b want 0000/1/1", countB, tickB, tcB); end
        compared++; if ({countA, tcA} !== {16'h9999, 1'b1}) begin mismatched++; $display("FAIL wrap_down got %h/%b want 9999/1", countA, tcA); end
        cycle(1);
        compared++; if ({countB, tickB, tcB} !== {16'h0000, 1'b1, 1'b1}) begin mismatched++; $display("FAIL sat_step3 got %h/%b/%b want 0000/1/1", countB, tickB, tcB); end
        compared++; if ({countA, tcA} !== {16'h9998, 1'b0}) begin mismatched++; $display("FAIL wrap_down2 got %h/%b want 9998/0", countA, tcA); end
        compared++; if (segB !== 32'hFFFFFFC0) begin mismatched++; $display("FAIL sat_seg got %h want FFFFFFC0", segB); end
        enable = 1'b0;
    endtask

    task automatic test_load_priority;
        logic tickErr;
        tickErr = 1'b0;
        enable = 1'b0;
        doLoad(16'h0A5F);
        compared++; if (countA !== 16'h0959) begin mismatched++; $display("FAIL load_clamp got %h want 0959", countA); end
        compared++; if (segB !== 32'hFF909290) begin mismatched++; $display("FAIL clamp_segB got %h want FF909290", segB); end
        presc_max = 26'd3; up_dn = 1'b1; enable = 1'b1;
        cycle(3);
        doLoad(16'h1234);
        compared++; if ({countA, tickA, tcA} !== {16'h1234, 1'b0, 1'b0}) begin mismatched++; $display("FAIL load_wins got %h/%b/%b want 1234/0/0", countA, tickA, tcA); end
        for (int k = 1; k <= 4; k++) begin
            cycle(1);
            if (tickA !== (k == 4)) begin
                tickErr = 1'b1;
                $display("FAIL load_presc_tick cycle %0d got %b want %b", k, tickA, k == 4);
            end
        end
        compared++; if (tickErr) mismatched++;
        compared++; if (countA !== 16'h1235) begin mismatched++; $display("FAIL after_load_step got %h want 1235", countA); end
        enable = 1'b0;
    endtask

    task automatic test_seg_font;
        enable = 1'b0;
        doLoad(16'h6789);
        compared++; if (segA !== 32'h82F88090) begin mismatched++; $display("FAIL seg_6789 got %h want 82F88090", segA); end
        doLoad(16'h1234);
        compared++; if (segB !== 32'hF9A4B099) begin mismatched++; $display("FAIL seg_1234 got %h want F9A4B099", segB); end
        doLoad(16'h0040);
        compared++; if (segA !== 32'hC0C099C0) begin mismatched++; $display("FAIL seg_0040A got %h want C0C099C0", segA); end
        compared++; if (segB !== 32'hFFFF99C0) begin mismatched++; $display("FAIL seg_0040B got %h want FFFF99C0", segB); end
        doLoad(16'h0305);
        compared++; if (segB !== 32'hFFB0C092) begin mismatched++; $display("FAIL seg_0305B got %h want FFB0C092", segB); end
        doLoad(16'h0000);
        compared++; if (segB !== 32'hFFFFFFC0) begin mismatched++; $display("FAIL seg_0000B got %h want FFFFFFC0", segB); end
    endtask

    task automatic test_presc_lower;
        logic sawTick;
        sawTick = 1'b0;
        presc_max = 26'd100; up_dn = 1'b1; enable = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            cycle(1);
            if (tickA !== 1'b0) sawTick = 1'b1;
        end
        compared++; if (sawTick) begin mismatched++; $display("FAIL presc_100_early_tick got 1 want 0"); end
        presc_max = 26'd5;
        cycle(1);
        compared++; if ({countA, tickA, tcA} !== {16'h0001, 1'b1, 1'b0}) begin mismatched++; $display("FAIL presc_lower got %h/%b/%b want 0001/1/0", countA, tickA, tcA); end
    endtask

    task automatic test_clr_mid;
        logic tickErr;
        tickErr = 1'b0;
        presc_max = 26'd0; enable = 1'b1; up_dn = 1'b1;
        cycle(3);
        compared++; if ({countA, tickA} !== {16'h0004, 1'b1}) begin mismatched++; $display("FAIL pre_clr got %h/%b want 0004/1", countA, tickA); end
        #2;
        clr = 1'b0;
        #1;
        compared++; if ({countA, tickA, tcA, countB, tickB} !== {16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0}) begin mismatched++; $display("FAIL async_clr got %h/%b/%b %h/%b want 0000/0/0 0000/0", countA, tickA, tcA, countB, tickB); end
        compared++; if (segA !== 32'hC0C0C0C0 || segB !== 32'hFFFFFFC0) begin mismatched++; $display("FAIL async_clr_seg got %h %h want C0C0C0C0 FFFFFFC0", segA, segB); end
        cycle(1);
        clr = 1'b1; presc_max = 26'd2;
        for (int k = 1; k <= 3; k++) begin
            cycle(1);
            if (tickA !== (k == 3)) begin
                tickErr = 1'b1;
                $display("FAIL restart_tick cycle %0d got %b want %b", k, tickA, k == 3);
            end
        end
        compared++; if (tickErr) mismatched++;
        compared++; if (countA !== 16'h0001) begin mismatched++; $display("FAIL restart_count got %h want 0001", countA); end
        enable = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_count_up();
        test_wrap_up();
        test_saturate_down();
        test_load_priority();
        test_seg_font();
        test_presc_lower();
        test_clr_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
